uart_tx: RTL

- Synthesizable UART transmitter in the SoC peripheral subsystem.
- Accepts bytes over a valid/ready interface and buffers them in a small FIFO.
- Serialises each byte onto the `tx_o` pin as an 8N1 frame, or 8E1 when parity is enabled.
- `tx_o` drives the line the testbench UART monitor samples and prints.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
//   uart_tx_state_e : transmit FSM states
//   UART_DATA_BITS  : data bits per frame
//   UART_STOP_BITS  : stop bits per frame
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_e;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous single-clock byte FIFO for the UART transmitter.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, data_i    : write request and byte (ignored when full)
//   pop_i, data_o     : read request and head byte (pop ignored when empty)
//   full_o, empty_o   : occupancy flags
//   count_o           : current occupancy
module uart_tx_fifo #(
   parameter  int FIFO_DEPTH = 8,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int CW         = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [7:0]    data_i,
   input  logic          pop_i,
   output logic [7:0]    data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (count_o == CW'(FIFO_DEPTH));
   assign empty_o = (count_o == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem[rd_ptr];

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_o <= count_o + CW'(1);
            2'b01:   count_o <= count_o - CW'(1);
            default: count_o <= count_o;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= data_i;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes from a valid/ready interface and sends
// them as 8N1 frames, or 8E1 when parity is enabled.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   cfg_div_i        : clocks per bit minus one (latched per frame)
//   cfg_parity_en_i  : append even parity bit (latched per frame)
//   data_i, valid_i  : byte input, accepted when valid_i & ready_o
//   ready_o          : FIFO has room
//   tx_o             : registered serial line, idles high
//   busy_o           : registered; frame in progress or FIFO non-empty
//   fifo_count_o     : FIFO occupancy
module uart_tx
   import uart_pkg::*;
#(
   parameter  int FIFO_DEPTH = 8,
   parameter  int DIV_W      = 16,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [DIV_W-1:0] cfg_div_i,
   input  logic             cfg_parity_en_i,
   input  logic [7:0]       data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             tx_o,
   output logic             busy_o,
   output logic [CW-1:0]    fifo_count_o
);

   localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
   localparam logic [2:0]       LAST_IDX = 3'(UART_DATA_BITS - 1);

   uart_tx_state_e   state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             par_en_q, par_en_d;
   logic             par_q, par_d;
   logic [2:0]       idx_q, idx_d;
   logic             tx_d;
   logic             pop;
   logic             load;
   logic             bit_end;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_data;

   uart_tx_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (valid_i),
      .data_i (data_i),
      .pop_i  (pop),
      .data_o (fifo_data),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .count_o(fifo_count_o)
   );

   // Derived from the registered count only, so a pop never makes a full
   // FIFO ready within the same cycle.
   assign ready_o = ~fifo_full;
   assign bit_end = (cnt_q == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         tx_o    <= 1'b1;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         tx_o    <= tx_d;
         busy_o  <= (state_q != IDLE) || (fifo_count_o != '0);
      end
   end

   // Frame data registers carry no reset: they are always loaded on pop
   // before being used.
   always_ff @(posedge clk_i) begin
      shift_q  <= shift_d;
      div_q    <= div_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
   end

   // tx_d is the line level for the state being entered, so tx_o changes on
   // the same edge as the state register.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      par_en_d = par_en_q;
      par_d    = par_q;
      idx_d    = idx_q;
      tx_d     = tx_o;
      pop      = 1'b0;
      load     = 1'b0;

      if (state_q != IDLE) cnt_d = bit_end ? div_q : cnt_q - ONE;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) load = 1'b1;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (idx_q == LAST_IDX) begin
                  if (par_en_q) begin
                     state_d = PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Start of a new frame: pop the head and latch this frame's config.
      if (load) begin
         pop      = 1'b1;
         shift_d  = fifo_data;
         div_d    = cfg_div_i;
         par_en_d = cfg_parity_en_i;
         par_d    = ^fifo_data;
         cnt_d    = cfg_div_i;
         state_d  = START;
         tx_d     = 1'b0;
      end
   end

endmodule
